fnd_scan_controller: RTL and testbench

Time-multiplexed 4-digit seven-segment (FND) display controller. Selects one of two 16-bit BCD/hex sources (mode), applies a display on/off blank, scans the four digits round-robin, and decodes the selected nibble to active-low segments. Sits between the counter datapath and the board FND pins and owns the two user buttons that drive mode and on/off.

---
 rtl/fnd_pkg.sv | 23 ++
 rtl/button_debouncer.sv | 39 +++
 rtl/fnd_scan_controller.sv | 85 ++++++++
 tb/tb_fnd_scan_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and the nibble-to-segment decoder
// for the four-digit FND scan controller.
package fnd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] DIG_OFF = 4'hF;

  // active-low a..g, dp (bit7) held off
  localparam logic [7:0] SEG_CODE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] seg_decode(
    input logic [3:0] nib
  );
    return SEG_CODE[nib];
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stable-count debouncer;
// emits the accepted level and a one-cycle rise pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
    end else begin
      sync   <= {sync[0], i_btn};
      o_rise <= 1'b0;
      if (sync[1] == o_level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        o_level <= sync[1];
        o_rise  <= sync[1];
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Four-digit time-multiplexed FND driver with debounced
// mode (source select) and on/off (blank) toggle buttons.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV        = 100_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_btn_mode,
  input  logic        i_btn_onOff,
  input  logic [15:0] i_value_a,
  input  logic [15:0] i_value_b,
  output logic [7:0]  o_seg,
  output logic [3:0]  o_digit,
  output logic        o_mode,
  output logic        o_onOff
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic          wrap;
  logic          mode_rise;
  logic          onoff_rise;
  logic          mode_level_unused;
  logic          onoff_level_unused;
  logic [15:0]   src;
  logic [3:0]    nib;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_mode (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_btn  (i_btn_mode),
    .o_level(mode_level_unused),
    .o_rise (mode_rise)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_onoff (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_btn  (i_btn_onOff),
    .o_level(onoff_level_unused),
    .o_rise (onoff_rise)
  );

  assign wrap = (pre == PW'(SCAN_DIV - 1));
  assign src  = o_mode ? i_value_b : i_value_a;
  assign nib  = src[{idx, 2'b00} +: 4];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre     <= '0;
      idx     <= '0;
      o_mode  <= 1'b0;
      o_onOff <= 1'b0;
    end else begin
      pre <= wrap ? '0 : pre + 1'b1;
      if (wrap) idx <= idx + 1'b1;
      if (mode_rise) o_mode <= ~o_mode;
      if (onoff_rise) o_onOff <= ~o_onOff;
    end
  end

  // blank at the pins: nibble F is a real digit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seg   <= SEG_BLANK;
      o_digit <= DIG_OFF;
    end else if (o_onOff) begin
      o_seg   <= SEG_BLANK;
      o_digit <= DIG_OFF;
    end else begin
      o_seg   <= seg_decode(nib);
      o_digit <= ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller: vector table,
// directed corner sequences and a randomized reference-model run.
module tb_fnd_scan_controller;

  localparam int SD = 4;
  localparam int DB = 8;

  localparam logic [7:0] SEG_REF [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct {
    logic [15:0] a;
    logic [7:0]  s[4];
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_onoff = 1'b0;
  logic [15:0] va = 16'h0;
  logic [15:0] vb = 16'h0;
  logic [7:0]  o_seg;
  logic [3:0]  o_digit;
  logic        o_mode;
  logic        o_onOff;

  int total = 0;
  int bad = 0;

  // reference model state
  int n;
  bit m_mode;
  bit m_onoff;
  bit acc[2];
  bit pend[2];
  bit win[2][DB+2];

  vec_t tab[4];

  always #5 clk = ~clk;

  fnd_scan_controller #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_btn_mode (btn_mode),
    .i_btn_onOff(btn_onoff),
    .i_value_a  (va),
    .i_value_b  (vb),
    .o_seg      (o_seg),
    .o_digit    (o_digit),
    .o_mode     (o_mode),
    .o_onOff    (o_onOff)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_mode = 0;
    m_onoff = 0;
    for (int b = 0; b < 2; b++) begin
      acc[b] = 0;
      pend[b] = 0;
      for (int i = 0; i < DB + 2; i++) win[b][i] = 0;
    end
  endtask

  // A level is accepted once the last DB synchronized samples
  // (raw samples two edges old) all disagree with it.
  task automatic step();
    logic [7:0]  es;
    logic [3:0]  ed;
    logic [15:0] src;
    int          id;
    int          nb;
    bit          raw[2];
    bit          flip;
    @(posedge clk);
    id  = (n / SD) % 4;
    src = m_mode ? vb : va;
    nb  = int'((src >> (4 * id)) & 16'hF);
    if (m_onoff) begin
      es = 8'hFF;
      ed = 4'hF;
    end else begin
      es = SEG_REF[nb];
      ed = 4'hF & ~(4'h1 << id);
    end
    n++;
    if (pend[0]) m_mode = !m_mode;
    if (pend[1]) m_onoff = !m_onoff;
    pend[0] = 0;
    pend[1] = 0;
    raw[0] = btn_mode;
    raw[1] = btn_onoff;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < DB + 1; i++) win[b][i] = win[b][i+1];
      win[b][DB+1] = raw[b];
      flip = 1;
      for (int i = 0; i < DB; i++) if (win[b][i] == acc[b]) flip = 0;
      if (flip) begin
        acc[b] = !acc[b];
        if (acc[b]) pend[b] = 1;
      end
    end
    #1;
    chk("seg", 32'(o_seg), 32'(es));
    chk("digit", 32'(o_digit), 32'(ed));
    chk("mode", 32'(o_mode), 32'(m_mode));
    chk("onoff", 32'(o_onOff), 32'(m_onoff));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    bit pm;
    bit po;
    int rem[2];
    bit lvl[2];

    tab[0].a = 16'h1234; tab[0].s = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    tab[1].a = 16'h5678; tab[1].s = '{8'h80, 8'hF8, 8'h82, 8'h92};
    tab[2].a = 16'h9ABC; tab[2].s = '{8'hC6, 8'h83, 8'h88, 8'h90};
    tab[3].a = 16'hDEF0; tab[3].s = '{8'hC0, 8'h8E, 8'h86, 8'hA1};

    model_reset();
    va = 16'h1234;
    vb = 16'h0000;
    #2 rst_n = 1'b0;
    #20;
    chk("rst_seg", 32'(o_seg), 32'hFF);
    chk("rst_digit", 32'(o_digit), 32'hF);
    chk("rst_mode", 32'(o_mode), 32'h0);
    chk("rst_onoff", 32'(o_onOff), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      va = tab[v].a;
      repeat (4 * SD) begin
        step();
        chk("tab_seg", 32'(o_seg), 32'(tab[v].s[((n - 1) / SD) % 4]));
      end
    end

    // mode toggle latency and source switch
    va = 16'h1234;
    vb = 16'hABCD;
    btn_mode = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      cnt++;
      if (o_mode) break;
    end
    chk("mode_latency", 32'(cnt), 32'd11);
    repeat (20 - cnt) step();
    btn_mode = 1'b0;
    repeat (16) step();

    // short bounces are rejected, a long hold is accepted
    repeat (4) begin
      btn_onoff = 1'b1;
      repeat (5) step();
      btn_onoff = 1'b0;
      repeat (3) step();
    end
    chk("bounce_off", 32'(o_onOff), 32'h0);
    btn_onoff = 1'b1;
    repeat (12) step();
    chk("onoff_set", 32'(o_onOff), 32'h1);
    btn_onoff = 1'b0;
    repeat (3) step();
    chk("blank_seg", 32'(o_seg), 32'hFF);
    chk("blank_digit", 32'(o_digit), 32'hF);
    repeat (12) step();
    btn_onoff = 1'b1;
    repeat (12) step();
    btn_onoff = 1'b0;
    chk("onoff_clr", 32'(o_onOff), 32'h0);
    repeat (12) step();

    // simultaneous presses flip both toggles together
    pm = m_mode;
    po = m_onoff;
    btn_mode = 1'b1;
    btn_onoff = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      cnt++;
      if (o_mode != pm) break;
    end
    chk("simul_lat", 32'(cnt), 32'd11);
    chk("simul_onoff", 32'(o_onOff), 32'(!po));
    btn_mode = 1'b0;
    btn_onoff = 1'b0;
    repeat (12) step();
    btn_mode = 1'b1;
    repeat (12) step();
    btn_mode = 1'b0;
    repeat (12) step();

    // async reset mid-slot at displayed idx 2
    for (int i = 0; i < 40; i++) begin
      if (((n - 1) / SD) % 4 == 2 && (n - 1) % SD == 1) break;
      step();
    end
    chk("pre_rst_mode", 32'(o_mode), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", 32'(o_seg), 32'hFF);
    chk("mid_rst_digit", 32'(o_digit), 32'hF);
    chk("mid_rst_mode", 32'(o_mode), 32'h0);
    chk("mid_rst_onoff", 32'(o_onOff), 32'h0);
    model_reset();
    #20;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("restart_digit", 32'(o_digit), 32'hE);

    // randomized run against the model
    rem[0] = 0;
    rem[1] = 0;
    repeat (1500) begin
      for (int b = 0; b < 2; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = 1'($urandom_range(0, 1));
          rem[b] = $urandom_range(1, 14);
        end
        rem[b]--;
      end
      btn_mode = lvl[0];
      btn_onoff = lvl[1];
      if ($urandom_range(0, 7) == 0) va = 16'($urandom);
      if ($urandom_range(0, 7) == 0) vb = 16'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
